half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered WIDTH-bit adder built from 1-bit half-adder cells.
- Computes a + b + cin and presents the sum and carry-out on registered outputs.
- Uses a valid/ready handshake so it can sit as an arithmetic stage inside a datapath pipeline.
- With WIDTH=1 and cin=0 it is a clocked classic half adder: y = a^b, carry = a&b.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- y  output  WIDTH  registered sum, (a + b + cin) mod 2^WIDTH
- carry  output  1  registered carry-out, bit WIDTH of a + b + cin
- cin  input  1  carry-in, added at bit 0
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- in_valid  input  1  a/b/cin are valid this cycle
- in_ready  output  1  stage can accept an operand set this cycle
- out_valid  output  1  y/carry hold a valid result
- out_ready  input  1  downstream accepts the result this cycle

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - y=0, carry=0, out_valid=0.
  - in_ready is combinational and therefore reads 1 while in reset-released idle.
  - Reset asserted mid-transfer discards the held result; no partial result survives.
- Arithmetic, unsigned:
  - {carry, y} = a + b + cin, computed at WIDTH+1 bits with no truncation before the carry.
  - Bit i: p_i = a_i ^ b_i, g_i = a_i & b_i (half-adder cell 1); y_i = p_i ^ c_i; c_{i+1} = g_i | (p_i & c_i), with p_i & c_i taken from half-adder cell 2; c_0 = cin.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational; single-entry stage, no skid buffer).
  - Accept when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
- Latency: exactly 1 cycle. Operands accepted on edge N produce y/carry and out_valid=1 after edge N.
- Per rising edge:
  - Accept: y/carry load the new result; out_valid <= 1.
  - Output transfer with no accept: out_valid <= 0; y/carry hold their last values.
  - Simultaneous transfer-out and accept: the new result replaces the old; out_valid stays 1. Full throughput of 1 result per cycle.
  - out_valid=1 and out_ready=0: in_ready=0; y/carry/out_valid hold stable until accepted (no data change while stalled).
  - in_valid=0 and no transfer: all state holds.
- Boundaries:
  - All-ones a and b with cin=1 gives y = all-ones, carry=1 (maximum value 2^(WIDTH+1)-1).
  - Zero operands with cin=0 give y=0, carry=0.
  - Inputs are ignored whenever in_ready=0.
  - X on a/b/cin while in_valid=0 must not propagate into state.

Decomposition:
- Package half_adder_pkg: default width constant HA_WIDTH_DEFAULT=8; typedef for the {carry, sum} result struct.
- Sub-module half_adder_cell: 1-bit inputs x, z; outputs s = x^z, c = x&z; purely combinational.
- The top instantiates 2*WIDTH cells in a generate loop plus the OR per bit, followed by the output register and handshake logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> y=0, carry=0, out_valid=0 immediately; in_ready=1 after release.
- Half-adder truth table, WIDTH=1, cin=0: (a,b) = 00, 01, 10, 11 -> (carry,y) = 00, 01, 01, 10, each one cycle after acceptance.
- Carry chain, WIDTH=8: a=8'hFF, b=8'h00, cin=1 -> y=8'h00, carry=1. Then a=8'hFF, b=8'hFF, cin=1 -> y=8'hFF, carry=1. Then a=8'h3C, b=8'h05, cin=0 -> y=8'h41, carry=0.
- Backpressure: result a=8'h10, b=8'h20 held with out_ready=0 for 3 cycles -> y=8'h30 stable, in_ready=0, and a new in_valid is ignored. Raising out_ready then transfers once.
- Throughput: in_valid=1 and out_ready=1 for 16 cycles with random operands -> 16 results in order, out_valid continuously 1, each equal to a+b+cin.
- Randomized 10k vectors with random stalls on both sides -> scoreboard matches {carry,y} = a+b+cin; no result lost or duplicated.

Source files
------------

// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared width default and the per-cell {carry, sum} result type.
package half_adder_pkg;

    localparam int HA_WIDTH_DEFAULT = 8;

    typedef struct packed {
        logic carry;
        logic sum;
    } ha_res_t;

endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: 1-bit half adder, s = x ^ z, c = x & z.
module half_adder_cell (
    input  logic x,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ z;
    assign c = x & z;

endmodule

// File: rtl/half_adder.sv
// half_adder: registered WIDTH-bit ripple adder built from half-adder cells,
// a single-entry valid/ready stage computing {carry, y} = a + b + cin.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready
);

    ha_res_t [WIDTH-1:0] h1;
    ha_res_t [WIDTH-1:0] h2;
    logic    [WIDTH:0]   c;
    logic    [WIDTH-1:0] sum;
    logic    [WIDTH-1:0] y_d, y_q;
    logic                carry_d, carry_q;
    logic                out_valid_d, out_valid_q;
    logic                acc;

    assign c[0] = cin;

    // Cell 1 gives propagate/generate, cell 2 folds in the incoming carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_adder_cell u_pg (
            .x(a[i]),
            .z(b[i]),
            .s(h1[i].sum),
            .c(h1[i].carry)
        );
        half_adder_cell u_pc (
            .x(h1[i].sum),
            .z(c[i]),
            .s(h2[i].sum),
            .c(h2[i].carry)
        );
        assign sum[i]   = h2[i].sum;
        assign c[i+1]   = h1[i].carry | h2[i].carry;
    end

    assign in_ready = ~out_valid_q | out_ready;
    assign acc      = in_valid & in_ready;

    // The select stays low when in_valid is low, so unknown operands never reach state.
    always_comb begin
        y_d         = acc ? sum : y_q;
        carry_d     = acc ? c[WIDTH] : carry_q;
        out_valid_d = acc | (out_valid_q & ~out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench for the registered adder stage (WIDTH=8 and WIDTH=1).
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b, y;
    logic       cin, in_valid, in_ready, out_valid, out_ready, carry;
    logic       a1, b1, cin1, iv1, ir1, ov1, or1, y1, c1;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] q[$];
    logic [8:0] exp;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .y(y), .carry(carry), .cin(cin), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready)
    );

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .y(y1), .carry(c1), .cin(cin1), .a(a1), .b(b1),
        .in_valid(iv1), .in_ready(ir1), .out_valid(ov1), .out_ready(or1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv1 = 1'b0; or1 = 1'b1; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #1;
        tests++;
        if ({carry, y, out_valid} !== 10'b0) begin
            fails++;
            $display("FAIL reset_init: carry,y,out_valid=%b required 0", {carry, y, out_valid});
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk); in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || {carry, y} !== 9'h034) begin
            fails++;
            $display("FAIL reset_pre_load: out_valid=%b result=%h required 1/034", out_valid, {carry, y});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({carry, y, out_valid} !== 10'b0) begin
            fails++;
            $display("FAIL reset_async: carry,y,out_valid=%b required 0", {carry, y, out_valid});
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] tt [4];
        logic [1:0] ab;
        tt = '{2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            @(negedge clk); iv1 = 1'b1; a1 = ab[1]; b1 = ab[0]; cin1 = 1'b0; or1 = 1'b1;
            @(posedge clk); #1; iv1 = 1'b0;
            tests++;
            if (ov1 !== 1'b1 || {c1, y1} !== tt[i]) begin
                fails++;
                $display("FAIL truth_%0d: out_valid=%b carry,y=%b required 1/%b", i, ov1, {c1, y1}, tt[i]);
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [8:0] te [3];
        ta = '{8'hFF, 8'hFF, 8'h3C};
        tb = '{8'h00, 8'hFF, 8'h05};
        tc = '{1'b1, 1'b1, 1'b0};
        te = '{9'h100, 9'h1FF, 9'h041};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (i < 3);
            if (i < 3) begin a = ta[i]; b = tb[i]; cin = tc[i]; end
            #1;
            if (out_valid && out_ready && q.size() > 0) begin
                exp = q.pop_front();
                tests++;
                if ({carry, y} !== exp) begin
                    fails++;
                    $display("FAIL carry_chain: carry,y=%h required %h", {carry, y}, exp);
                end
            end
            if (in_valid && in_ready) q.push_back(te[i]);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL carry_chain_drain: %0d results outstanding required 0", q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk); in_valid = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({carry, y} !== 9'h030 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_%0d: result=%h out_valid=%b in_ready=%b required 030/1/0",
                         i, {carry, y}, out_valid, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || {carry, y} !== 9'h030) begin
            fails++;
            $display("FAIL stall_release: out_valid=%b result=%h required 0/030", out_valid, {carry, y});
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_single_transfer: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_throughput();
        int pops = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (i < 16);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            #1;
            if (i > 0) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL throughput_valid_%0d: out_valid=%b required 1", i, out_valid);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp = q.pop_front();
                pops++;
                tests++;
                if ({carry, y} !== exp) begin
                    fails++;
                    $display("FAIL throughput_data: carry,y=%h required %h", {carry, y}, exp);
                end
            end
            if (in_valid && in_ready) q.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
        end
        in_valid = 1'b0;
        tests++;
        if (pops != 16) begin
            fails++;
            $display("FAIL throughput_count: %0d results required 16", pops);
        end
    endtask

    task automatic test_random();
        int pushes = 0;
        int pops = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < 70);
            in_valid  = ($urandom_range(99) < 70);
            if (in_valid) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                a = 'x; b = 'x; cin = 1'bx;
            end
            #1;
            tests++;
            if (in_ready !== (!out_valid || out_ready)) begin
                fails++;
                $display("FAIL random_ready: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL random_dup: result %h with empty scoreboard", {carry, y});
                end else begin
                    exp = q.pop_front();
                    pops++;
                    tests++;
                    if ({carry, y} !== exp) begin
                        fails++;
                        $display("FAIL random_data: carry,y=%h required %h", {carry, y}, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
                pushes++;
            end
        end
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp = q.pop_front();
                pops++;
                tests++;
                if ({carry, y} !== exp) begin
                    fails++;
                    $display("FAIL random_drain: carry,y=%h required %h", {carry, y}, exp);
                end
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        #1;
        tests++;
        if (q.size() != 0 || pops != pushes || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_count: pushes=%0d pops=%0d left=%0d out_valid=%b required equal/0/0",
                     pushes, pops, q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_carry_chain();
        test_backpressure();
        test_throughput();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
